// File: rtl/cache_bus_burst_ctrl_pkg.sv
// Shared AHB-Lite encodings and burst-state type for the cache bus burst engine.
// The optional HRESP abort path in the top is enabled by defining CACHE_BUS_HRESP_EN.
package cache_bus_burst_ctrl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    FETCH     = 2'b01,
    WRITEBACK = 2'b10,
    DONE      = 2'b11
  } busstate_t;

  // Fixed-length INCR encoding for a line of the given beat count; odd sizes fall back to INCR.
  function automatic logic [2:0] hburstFor(input int unsigned beats);
    case (beats)
      1:       return HBURST_SINGLE;
      4:       return HBURST_INCR4;
      8:       return HBURST_INCR8;
      16:      return HBURST_INCR16;
      default: return HBURST_INCR;
    endcase
  endfunction

endpackage

// File: rtl/cache_bus_burst_ctrl_beat_counter.sv
// Enabled beat counter that wraps to zero after LAST, with synchronous clear and a
// terminal-count flag; used for both address-phase and data-phase beats.
module cache_bus_burst_ctrl_beat_counter #(
  parameter int unsigned W    = 3,
  parameter int unsigned LAST = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         tc
);

  assign tc = (count == W'(LAST));

  always_ff @(posedge clk) begin
    if (reset || clear) count <= '0;
    else if (en)        count <= tc ? '0 : count + W'(1);
  end

endmodule

// File: rtl/cache_bus_burst_ctrl.sv
// AHB-Lite INCR burst engine for cache line fetch and writeback.
// Define CACHE_BUS_HRESP_EN to add HRESP/BusErr and abort a burst on a bus error.
module cache_bus_burst_ctrl
  import cache_bus_burst_ctrl_pkg::*;
#(
  parameter int unsigned PA_BITS = 32,
  parameter int unsigned AHBW    = 64,
  parameter int unsigned LINELEN = 512,
  parameter int unsigned LOGBWPL = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               Stall,
  input  logic               FlushStage,
  input  logic [1:0]         CacheBusRW,
  input  logic [PA_BITS-1:0] CacheBusAdr,
  input  logic [AHBW-1:0]    ReadDataWord,
  output logic               CacheBusAck,
  output logic               SelBusBeat,
  output logic [LOGBWPL-1:0] BeatCount,
  output logic [LINELEN-1:0] FetchBuffer,
  output logic               BusCommitted,
  output logic [PA_BITS-1:0] HADDR,
  output logic [1:0]         HTRANS,
  output logic               HWRITE,
  output logic [2:0]         HBURST,
  output logic [2:0]         HSIZE,
  output logic [AHBW-1:0]    HWDATA,
  input  logic               HREADY,
  input  logic [AHBW-1:0]    HRDATA
`ifdef CACHE_BUS_HRESP_EN
  ,
  input  logic               HRESP,
  output logic               BusErr
`endif
);

  localparam int unsigned BEATS      = LINELEN / AHBW;
  localparam int unsigned BYTE_SHIFT = $clog2(AHBW / 8);

  busstate_t            state;
  logic [PA_BITS-1:0]   baseAdr;
  logic [LINELEN-1:0]   fetchBuf;
  logic                 adrDone;
  logic                 dataActive;
  logic [LOGBWPL-1:0]   adrBeat;
  logic [LOGBWPL-1:0]   dataBeat;
  logic                 adrLast;
  logic                 dataLast;

  logic startC, inBurst, adrPhase, adrAccept, dataAccept, lastData, errC, finish;

  assign startC     = (state == IDLE) && (CacheBusRW != 2'b00) && !FlushStage;
  assign inBurst    = (state == FETCH) || (state == WRITEBACK);
  assign adrPhase   = startC || (inBurst && !adrDone);
  assign adrAccept  = adrPhase && HREADY;
  assign dataAccept = inBurst && dataActive && HREADY;
  assign lastData   = dataAccept && dataLast;

`ifdef CACHE_BUS_HRESP_EN
  assign errC   = dataAccept && HRESP;
  assign BusErr = errC;
`else
  assign errC = 1'b0;
`endif

  assign finish      = lastData || errC;
  assign CacheBusAck = finish;
  assign BeatCount   = adrBeat;
  assign HBURST      = hburstFor(BEATS);
  assign HSIZE       = 3'(BYTE_SHIFT);

  cache_bus_burst_ctrl_beat_counter #(.W(LOGBWPL), .LAST(BEATS - 1)) u_adrBeat (
    .clk   (clk),
    .reset (reset),
    .clear (finish),
    .en    (adrAccept),
    .count (adrBeat),
    .tc    (adrLast)
  );

  cache_bus_burst_ctrl_beat_counter #(.W(LOGBWPL), .LAST(BEATS - 1)) u_dataBeat (
    .clk   (clk),
    .reset (reset),
    .clear (finish),
    .en    (dataAccept),
    .count (dataBeat),
    .tc    (dataLast)
  );

  // Address phase is combinational so the first beat goes out in the request cycle.
  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = '0;
    HWRITE = 1'b0;
    if (startC) begin
      HTRANS = HTRANS_NONSEQ;
      HADDR  = CacheBusAdr;
      HWRITE = CacheBusRW[0];
    end else if (inBurst) begin
      HADDR  = baseAdr + (PA_BITS'(adrBeat) << BYTE_SHIFT);
      HWRITE = (state == WRITEBACK);
      if (!adrDone) HTRANS = (adrBeat == '0) ? HTRANS_NONSEQ : HTRANS_SEQ;
    end
  end

  // Final fetched word bypasses the buffer so the line is whole in the ack cycle.
  always_comb begin
    FetchBuffer = fetchBuf;
    if ((state == FETCH) && lastData)
      FetchBuffer[(BEATS-1)*AHBW +: AHBW] = HRDATA;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      baseAdr      <= '0;
      fetchBuf     <= '0;
      HWDATA       <= '0;
      adrDone      <= 1'b0;
      dataActive   <= 1'b0;
      SelBusBeat   <= 1'b0;
      BusCommitted <= 1'b0;
    end else begin
      if (HREADY) dataActive <= adrPhase && !errC;

      if (finish)                  adrDone <= 1'b0;
      else if (adrAccept && adrLast) adrDone <= 1'b1;

      // Write data follows its address beat into the data phase.
      if (adrAccept && (startC ? CacheBusRW[0] : (state == WRITEBACK)))
        HWDATA <= ReadDataWord;

      if ((state == FETCH) && dataAccept)
        fetchBuf[32'(dataBeat)*AHBW +: AHBW] <= HRDATA;

      case (state)
        IDLE: begin
          if (startC) begin
            baseAdr      <= CacheBusAdr;
            state        <= CacheBusRW[0] ? WRITEBACK : FETCH;
            SelBusBeat   <= CacheBusRW[0];
            BusCommitted <= 1'b1;
          end
        end
        FETCH, WRITEBACK: begin
          if (finish) begin
            state        <= DONE;
            SelBusBeat   <= 1'b0;
            BusCommitted <= 1'b0;
          end
        end
        DONE: begin
          if (!Stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_bus_burst_ctrl.sv
// Randomized bench for cache_bus_burst_ctrl: an AHB slave with a hashed memory and a
// transaction-level model of the burst (beat index, pipeline depth, expected ack cycle).
module tb_cache_bus_burst_ctrl;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         reset, Stall, FlushStage, HREADY;
  logic [1:0]   CacheBusRW;
  logic [31:0]  CacheBusAdr;
  logic [63:0]  ReadDataWord, HRDATA, HWDATA;
  logic         CacheBusAck, SelBusBeat, BusCommitted, HWRITE;
  logic [2:0]   BeatCount, HBURST, HSIZE;
  logic [511:0] FetchBuffer;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
`ifdef CACHE_BUS_HRESP_EN
  logic         HRESP, BusErr;
`endif

  logic [63:0] wbPat;
  int total = 0;
  int bad   = 0;

  cache_bus_burst_ctrl dut (
    .clk(clk), .reset(reset), .Stall(Stall), .FlushStage(FlushStage),
    .CacheBusRW(CacheBusRW), .CacheBusAdr(CacheBusAdr), .ReadDataWord(ReadDataWord),
    .CacheBusAck(CacheBusAck), .SelBusBeat(SelBusBeat), .BeatCount(BeatCount),
    .FetchBuffer(FetchBuffer), .BusCommitted(BusCommitted), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HBURST(HBURST), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA)
`ifdef CACHE_BUS_HRESP_EN
    , .HRESP(HRESP), .BusErr(BusErr)
`endif
  );

  always #5 clk = ~clk;

  // Cache side: word at BeatCount of the line being written back.
  assign ReadDataWord = wbPat + 64'(BeatCount);

  function automatic logic [63:0] memWord(input logic [31:0] a);
    return {a ^ 32'h5a5a_0f0f, ~a};
  endfunction

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One line transfer; resetAt/errBeat < 0 disable those events, stallCycles holds DONE.
  task automatic burst(input logic [1:0] rw, input logic [31:0] adr, input int mode,
                       input int flushAt, input int resetAt, input int errBeat,
                       input int stallCycles);
    bit           hr[64];
    bit           isWb = rw[0];
    int           stopBeat = (errBeat >= 0) ? errBeat : N - 1;
    int           highs = 0;
    int           expAck = -1;
    int           abeat = 0;
    int           dbeat = 0;
    bit           dphValid = 0;
    logic [31:0]  dphAdr = '0;
    bit           accNow;
    logic [31:0]  accAdr;
    logic [511:0] expLine = '0;

    for (int c = 0; c < 64; c++) begin
      if (mode == 0)      hr[c] = 1'b1;
      else if (mode == 1) hr[c] = (c % 2 == 0);
      else                hr[c] = (c >= 40) || ($urandom_range(0, 2) != 0);
      if (hr[c]) highs++;
      if (hr[c] && highs == stopBeat + 2 && expAck < 0) expAck = c;
    end
    for (int k = 0; k < N; k++) expLine[k*64 +: 64] = memWord(adr + 32'(8 * k));

    CacheBusAdr = adr;
    CacheBusRW  = rw;
    for (int c = 0; c < 64; c++) begin
      HREADY     = hr[c];
      HRDATA     = dphValid ? memWord(dphAdr) : 64'(0);
      FlushStage = (c == flushAt);
      Stall      = 1'($urandom);
      if (c > 0) CacheBusRW = 2'($urandom);
      if (c == resetAt) reset = 1'b1;
`ifdef CACHE_BUS_HRESP_EN
      HRESP = dphValid && hr[c] && (dbeat == errBeat);
`endif
      @(negedge clk);
      accNow = 0;
      accAdr = '0;
      if (abeat < N) begin
        check("htrans", HTRANS, (abeat == 0) ? 2'b10 : 2'b11);
        check("haddr", HADDR, adr + 32'(8 * abeat));
        check("hwrite", HWRITE, isWb);
        if (hr[c]) begin accNow = 1; accAdr = HADDR; end
      end else begin
        check("htrans_tail", HTRANS, 2'b00);
      end
      check("beatcount", BeatCount, abeat % N);
      if (c == 0) check("commit_c0", BusCommitted, 1'b0);
      else begin
        check("selbeat", SelBusBeat, isWb);
        check("commit", BusCommitted, 1'b1);
      end
      if (dphValid && isWb) check("hwdata", HWDATA, wbPat + 64'(dbeat));
      check("ack", CacheBusAck, c == expAck);
`ifdef CACHE_BUS_HRESP_EN
      check("buserr", BusErr, (c == expAck) && (errBeat >= 0));
`endif
      if (c == expAck && !isWb && errBeat < 0) check("line_at_ack", FetchBuffer, expLine);
      @(posedge clk); #1;
      if (c == resetAt) begin
        reset = 1'b0; CacheBusRW = 2'b00; FlushStage = 1'b0; Stall = 1'b0; HREADY = 1'b1;
        @(negedge clk);
        check("rst_htrans", HTRANS, 2'b00);
        check("rst_beat", BeatCount, 3'd0);
        check("rst_commit", BusCommitted, 1'b0);
        check("rst_ack", CacheBusAck, 1'b0);
        @(posedge clk); #1;
        return;
      end
      if (c == expAck) break;
      if (hr[c]) begin
        if (dphValid) dbeat++;
        dphValid = accNow;
        dphAdr   = accAdr;
        if (accNow) abeat++;
      end
    end

`ifdef CACHE_BUS_HRESP_EN
    HRESP = 1'b0;
`endif
    // DONE: requests are ignored until Stall drops, then one cycle to reach IDLE.
    for (int s = 0; s <= stallCycles; s++) begin
      Stall      = (s < stallCycles);
      CacheBusRW = (s < stallCycles) ? 2'($urandom_range(1, 3)) : 2'b00;
      FlushStage = 1'b0;
      HREADY     = 1'($urandom);
      @(negedge clk);
      check("done_htrans", HTRANS, 2'b00);
      check("done_ack", CacheBusAck, 1'b0);
      check("done_commit", BusCommitted, 1'b0);
      if (!isWb && errBeat < 0) check("line_hold", FetchBuffer, expLine);
      @(posedge clk); #1;
    end
    Stall = 1'b0;
  endtask

  task automatic flushIdle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      CacheBusRW = 2'b10; FlushStage = 1'b1; HREADY = 1'b1;
      @(negedge clk);
      check("flush_htrans", HTRANS, 2'b00);
      check("flush_ack", CacheBusAck, 1'b0);
      check("flush_commit", BusCommitted, 1'b0);
      @(posedge clk); #1;
    end
    FlushStage = 1'b0;
    CacheBusRW = 2'b00;
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; FlushStage = 1'b0; CacheBusRW = 2'b00;
    CacheBusAdr = 32'h0; HREADY = 1'b1; HRDATA = 64'h0; wbPat = 64'h0;
`ifdef CACHE_BUS_HRESP_EN
    HRESP = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_htrans0", HTRANS, 2'b00);
    check("rst_haddr0", HADDR, 32'h0);
    check("rst_hwrite0", HWRITE, 1'b0);
    check("rst_beat0", BeatCount, 3'd0);
    check("rst_ack0", CacheBusAck, 1'b0);
    check("rst_sel0", SelBusBeat, 1'b0);
    check("rst_commit0", BusCommitted, 1'b0);
    check("rst_fbuf0", FetchBuffer, 512'h0);
    check("rst_hwdata0", HWDATA, 64'h0);
    check("hburst", HBURST, 3'b101);
    check("hsize", HSIZE, 3'b011);
    @(posedge clk); #1;
    reset = 1'b0;

    wbPat = 64'hA0;
    burst(2'b10, 32'h8000_0040, 0, -1, -1, -1, 0);
    burst(2'b01, 32'h8000_0040, 0, -1, -1, -1, 0);
    burst(2'b10, 32'h8000_0040, 1, -1, -1, -1, 0);
    flushIdle(3);
    burst(2'b10, 32'h8000_0100, 0, 3, -1, -1, 0);
    burst(2'b11, 32'h8000_0200, 2, -1, -1, -1, 3);
    burst(2'b01, 32'h8000_0300, 0, -1, 4, -1, 0);
`ifdef CACHE_BUS_HRESP_EN
    burst(2'b10, 32'h8000_0400, 0, -1, -1, 2, 1);
`endif
    for (int i = 0; i < 20; i++) begin
      wbPat = {$urandom, $urandom};
      burst(2'($urandom_range(1, 3)), $urandom & 32'hFFFF_FFC0, 2,
            $urandom_range(1, 10), -1, -1, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_bus_burst_ctrl.md
Name: cache_bus_burst_ctrl

Overview:
- Bus-side burst engine directly downstream of the I$/D$ array controller.
- Accepts a line fetch or line writeback request (CacheBusRW, CacheBusAdr) and runs an AHB-Lite INCR burst of LINELEN/AHBW beats.
- For fetches, assembles the line in FetchBuffer. For writebacks, steps BeatCount so the cache streams words out.
- Returns a one-cycle CacheBusAck when the burst completes.

Parameters:
- PA_BITS, 32, physical address width.
- AHBW, 64, bus data width in bits; equals cache WORDLEN.
- LINELEN, 512, cache line width in bits.
- LOGBWPL, 3, log2(LINELEN/AHBW), the beat counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- Stall  in  1  pipeline stall; holds the done state until released.
- FlushStage  in  1  flush of the requesting stage; suppresses a burst start only.
- CacheBusRW  in  2  [1] line fetch, [0] line writeback.
- CacheBusAdr  in  PA_BITS  line-aligned bus address.
- ReadDataWord  in  AHBW  cache word at BeatCount (writeback data).
- CacheBusAck  out  1  burst complete, one-cycle pulse.
- SelBusBeat  out  1  cache must index its word by BeatCount.
- BeatCount  out  LOGBWPL  address-phase beat index.
- FetchBuffer  out  LINELEN  assembled fetched line.
- BusCommitted  out  1  burst in flight, not interruptible.
- HADDR  out  PA_BITS  bus address.
- HTRANS  out  2  IDLE=00, NONSEQ=10, SEQ=11.
- HWRITE  out  1  write transfer.
- HBURST  out  3  INCR4=011, INCR8=101, INCR16=111, SINGLE=000 for 1 beat.
- HSIZE  out  3  log2(AHBW/8).
- HWDATA  out  AHBW  write data.
- HREADY  in  1  bus ready.
- HRDATA  in  AHBW  read data.

Behaviour:
- Reset values:
  - State IDLE; HTRANS=00, HWRITE=0, HADDR=0.
  - BeatCount=0, CacheBusAck=0, SelBusBeat=0, BusCommitted=0.
  - FetchBuffer=0, HWDATA=0.
- States: IDLE, FETCH, WRITEBACK, DONE.
- IDLE:
  - CacheBusRW!=0 & ~FlushStage starts a burst; HTRANS=NONSEQ and HADDR=CacheBusAdr in the same cycle (combinational address phase).
  - Bit [0] has priority: if RW=11, WRITEBACK is taken; fetch must be re-requested after the ack.
  - FlushStage=1 keeps the block in IDLE with HTRANS=00.
- Beat sequencing:
  - AdrBeat (=BeatCount) increments on each HREADY while the address phase is active.
  - DataBeat is a registered copy, advancing only on HREADY.
  - HADDR = CacheBusAdr + (AdrBeat << log2(AHBW/8)); HTRANS=SEQ for beats 1..N-1.
  - After address beat N-1 is accepted, HTRANS=IDLE while the last data phase completes.
- HREADY=0: all of HADDR, HTRANS, HWDATA and both counters hold.
- FETCH: on HREADY in a data phase, HRDATA is written to FetchBuffer[DataBeat*AHBW +: AHBW]; all other slices hold.
- WRITEBACK:
  - SelBusBeat=1.
  - HWDATA is registered from ReadDataWord when the address beat is accepted on HREADY, so it is valid in that beat's data phase.
- Completion:
  - CacheBusAck=1 for exactly the cycle in which the final data phase has HREADY=1; the next state is DONE.
  - FetchBuffer is complete in the ack cycle.
- DONE:
  - HTRANS=00.
  - Stay while Stall=1; go to IDLE when Stall=0.
  - A new request is honoured only from IDLE, so there are no back-to-back starts and the cache has a cycle to deassert CacheBusRW.
- Mid-burst conditions:
  - BusCommitted=1 in FETCH and WRITEBACK.
  - FlushStage and CacheBusRW changes are ignored mid-burst.
  - reset mid-burst returns to IDLE next edge with HTRANS=00; bus-side abandonment is acceptable.
- BeatCount wraps to 0 after beat N-1; no counter overflow is visible.

Optional Feature:
- Macro: CACHE_BUS_HRESP_EN.
- Defined:
  - Input port HRESP (1) and output port BusErr (1) are added.
  - HRESP=1 during any data phase with HREADY=1 drives HTRANS=IDLE the next cycle and aborts the burst.
  - CacheBusAck and BusErr pulse together in that cycle; the FetchBuffer contents are undefined.
  - State goes to DONE.
- Undefined: no HRESP/BusErr ports; bus errors are not observed.

Decomposition:
- Shared package (cvw or a cache package) holds:
  - HTRANS encodings: HTRANS_IDLE, HTRANS_NONSEQ, HTRANS_SEQ.
  - HBURST encodings.
  - An enum busstate_t {IDLE, FETCH, WRITEBACK, DONE}.
  - A function mapping beats-per-line to HBURST.
- One natural sub-module, beat_counter: an LOGBWPL-bit enabled counter with synchronous clear and terminal-count flag. It is instantiated twice, for address beats and data beats.

Test Plan:
- Fetch, LINELEN=512, AHBW=64, HREADY=1, CacheBusRW=10, CacheBusAdr=0x8000_0040, HRDATA=beat index:
  - HADDR steps 0x40..0x78 by 8; HBURST=101.
  - CacheBusAck pulses in cycle 9.
  - FetchBuffer slice k = k.
- Writeback, CacheBusRW=01, ReadDataWord=0xA0+BeatCount:
  - HWRITE=1, SelBusBeat=1.
  - HWDATA sequence 0xA0..0xA7 aligned to data phases; single ack.
- Same fetch with HREADY low on alternate cycles:
  - HADDR, HTRANS and HWDATA hold while low.
  - Ack comes after 16 cycles; FetchBuffer identical to the first test.
- CacheBusRW=10 with FlushStage=1 in IDLE:
  - HTRANS stays 00 and no ack.
  - FlushStage asserted at beat 3 of a burst has no effect; the burst completes.
- Stall=1 during the ack cycle:
  - DONE is held while Stall=1; a request presented then is ignored.
  - IDLE is reached one cycle after Stall=0; the next burst starts from IDLE.
- reset asserted at beat 4 of a writeback: next cycle HTRANS=00, BeatCount=0, BusCommitted=0, no ack.
- With CACHE_BUS_HRESP_EN, HRESP=1 on beat 2: abort, CacheBusAck and BusErr pulse together, then DONE.
